robot_nav_fsm: RTL and testbench
================================

Name: robot_nav_fsm

Overview:
Parametrised successor to the robot chase controller. Steers toward a bell-triggered target using a ZONES-wide one-hot pixel-location vector, with graded turn strength, proximity debounce, lost-target hold-over and search timeout. Sits between the vision zone decoder / proximity sensor and the motor driver. Keeps the existing one-hot 5-bit motor command encoding.

Parameters:
ZONES, 3, pixel zones; odd and >= 3; centre index C = ZONES/2
PROX_CYCLES, 4, consecutive high samples needed before proximity counts as valid
LOST_HOLD, 8, cycles the last steering command is held after the target is lost
SEARCH_TIMEOUT, 50_000_000, SEARCH cycles before giving up and returning to IDLE

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
bell  in  1  summon request; level input, rising edge used
proximity  in  1  raw obstacle/target-near sensor
button1  in  1  user acknowledge
pixel_location  in  ZONES  target zone; bit 0 = rightmost, bit ZONES-1 = leftmost
motor_state  out  5  one-hot: 00001 STOP, 00010 FORWARD, 00100 RIGHT, 01000 LEFT, 10000 SPIN
turn_level  out  $clog2(C+1)  |zone index - C| while turning, else 0
overwrite  out  1  recall-in-progress flag
search_timeout  out  1  one-cycle pulse on search give-up
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, asserts immediately): state IDLE; motor_state 00001; turn_level 0; overwrite 0; search_timeout 0; all counters 0; bell_q 0.
- bell_rise = bell & ~bell_q, where bell_q is bell registered.
- valid = pixel_location has exactly one bit set; idx = that bit's index. Zero or multiple bits set = invalid (no target).
- prox_f: counter increments while proximity = 1 and saturates at PROX_CYCLES. It clears to 0 in the cycle proximity = 0. prox_f = (count == PROX_CYCLES).
- States and transitions (evaluated every edge, listed in priority order):
  - IDLE: bell_rise -> SEARCH.
  - SEARCH:
    - valid -> TRACK.
    - else search_cnt == SEARCH_TIMEOUT-1 -> IDLE, with search_timeout = 1 for one cycle.
    - search_cnt clears on entry to SEARCH and increments each SEARCH cycle.
  - TRACK:
    - prox_f -> STOP.
    - else valid -> TRACK; latch dir/turn_level from idx; lost_cnt = 0.
    - else lost_cnt == LOST_HOLD-1 -> SEARCH.
    - else stay in TRACK, hold last dir, lost_cnt += 1.
  - STOP: !prox_f -> SEARCH; else (valid and idx == C) -> ARRIVED; else stay.
  - ARRIVED: -> WAIT_ACK unconditionally; overwrite cleared on this transition.
  - WAIT_ACK: button1 -> IDLE; else bell_rise -> RECALL.
  - RECALL: -> SEARCH unconditionally; overwrite set to 1 on entry; held until the next ARRIVED or reset.
- Outputs are registered and decoded from next_state, so they change on the same edge as the state:
  - SEARCH: SPIN.
  - TRACK: idx == C gives FORWARD; idx < C gives RIGHT; idx > C gives LEFT.
  - All other states: STOP, turn_level 0.
- TRACK hold-over keeps motor_state and turn_level unchanged.
- Simultaneous events follow the priority order above, e.g. in WAIT_ACK, button1 beats bell_rise.
- Reset mid-operation returns everything to reset values; a bell already held high does not re-trigger until it falls and rises again.

Test Plan:
Use ZONES=5, PROX_CYCLES=4, LOST_HOLD=3, SEARCH_TIMEOUT=20.
1. Reset, then bell 0->1 -> busy=1 and motor_state 10000 on the next edge. Then pixel_location 00100 -> motor_state 00010, turn_level 0.
2. In TRACK, pixel 00001 -> motor_state 00100, turn_level 2. Pixel 01000 -> 01000, turn_level 1. Pixel 00011 (invalid) for 2 cycles -> 01000 held. Third invalid cycle -> SEARCH (10000).
3. In TRACK, proximity high for 3 cycles then low -> stays TRACK. High for 4 cycles -> STOP (00001). Pixel 00100 -> ARRIVED, then WAIT_ACK on the next edge.
4. In WAIT_ACK, bell rise -> RECALL, overwrite=1, then SEARCH. In WAIT_ACK, button1 and bell_rise on the same cycle -> IDLE, overwrite unchanged.
5. In SEARCH with pixel 00000 for 20 cycles -> IDLE, search_timeout high for exactly 1 cycle, busy=0.
6. Assert reset mid-TRACK with bell held high -> immediate reset values; no SEARCH entry until bell falls and rises again.

Source files
------------

// File: rtl/robot_nav_fsm.sv
`default_nettype none
// ============================================================================
// Module   : robot_nav_fsm
// Brief    : Bell-summoned target-chase controller with graded steering,
//            proximity debounce, lost-target hold-over and search timeout.
// Revision : 1.0
// ============================================================================
module robot_nav_fsm #(
    parameter int ZONES          = 3,
    parameter int PROX_CYCLES    = 4,
    parameter int LOST_HOLD      = 8,
    parameter int SEARCH_TIMEOUT = 50_000_000
) (
    input  logic                             CLOCK_50,
    input  logic                             reset,
    input  logic                             bell,
    input  logic                             proximity,
    input  logic                             button1,
    input  logic [ZONES-1:0]                 pixel_location,
    output logic [4:0]                       motor_state,
    output logic [$clog2(ZONES/2+1)-1:0]     turn_level,
    output logic                             overwrite,
    output logic                             search_timeout,
    output logic                             busy
);

    localparam int c_centre = ZONES / 2;
    localparam int c_tlw    = $clog2(c_centre + 1);
    localparam int c_iw     = $clog2(ZONES);
    localparam int c_pw     = $clog2(PROX_CYCLES + 1);
    localparam int c_lw     = $clog2(LOST_HOLD + 1);
    localparam int c_sw     = $clog2(SEARCH_TIMEOUT + 1);

    localparam logic [c_iw-1:0] c_centre_idx  = c_iw'(c_centre);
    localparam logic [c_pw-1:0] c_prox_full   = c_pw'(PROX_CYCLES);
    localparam logic [c_lw-1:0] c_lost_last   = c_lw'(LOST_HOLD - 1);
    localparam logic [c_sw-1:0] c_search_last = c_sw'(SEARCH_TIMEOUT - 1);

    localparam logic [4:0] c_mot_stop  = 5'b00001;
    localparam logic [4:0] c_mot_fwd   = 5'b00010;
    localparam logic [4:0] c_mot_right = 5'b00100;
    localparam logic [4:0] c_mot_left  = 5'b01000;
    localparam logic [4:0] c_mot_spin  = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEARCH   = 3'd1,
        S_TRACK    = 3'd2,
        S_STOP     = 3'd3,
        S_ARRIVED  = 3'd4,
        S_WAIT_ACK = 3'd5,
        S_RECALL   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [4:0]        r_motor,       w_next_motor;
    logic [c_tlw-1:0]  r_turn,        w_next_turn;
    logic              r_overwrite,   w_next_overwrite;
    logic              r_timeout,     w_next_timeout;
    logic [c_pw-1:0]   r_prox_cnt,    w_next_prox;
    logic [c_lw-1:0]   r_lost_cnt,    w_next_lost;
    logic [c_sw-1:0]   r_search_cnt,  w_next_search;
    logic              r_bell_q;
    logic              r_bell_seen;

    logic              w_bell_rise;
    logic              w_prox_f;
    logic              w_seen;
    logic              w_multi;
    logic              w_valid;
    logic [c_iw-1:0]   w_idx;
    logic [c_tlw-1:0]  w_turn;
    logic [4:0]        w_dir;

    // r_bell_seen suppresses a false edge when bell is already high as reset releases.
    assign w_bell_rise = bell & ~r_bell_q & r_bell_seen;
    assign w_prox_f    = (r_prox_cnt == c_prox_full);
    assign w_next_prox = !proximity ? '0 : (w_prox_f ? r_prox_cnt : r_prox_cnt + 1'b1);

    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < ZONES; i++) begin
            if (pixel_location[i]) begin
                if (w_seen) w_multi = 1'b1;
                w_seen = 1'b1;
                w_idx  = c_iw'(i);
            end
        end
        w_valid = w_seen & ~w_multi;
    end

    always_comb begin
        w_turn = '0;
        w_dir  = c_mot_fwd;
        if (w_idx > c_centre_idx) begin
            w_turn = c_tlw'(w_idx - c_centre_idx);
            w_dir  = c_mot_left;
        end else if (w_idx < c_centre_idx) begin
            w_turn = c_tlw'(c_centre_idx - w_idx);
            w_dir  = c_mot_right;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_motor     = r_motor;
        w_next_turn      = r_turn;
        w_next_overwrite = r_overwrite;
        w_next_timeout   = 1'b0;
        w_next_lost      = '0;
        w_next_search    = '0;

        case (r_state)
            S_IDLE: begin
                if (w_bell_rise) w_next_state = S_SEARCH;
            end
            S_SEARCH: begin
                if (w_valid) begin
                    w_next_state = S_TRACK;
                end else if (r_search_cnt == c_search_last) begin
                    w_next_state   = S_IDLE;
                    w_next_timeout = 1'b1;
                end else begin
                    w_next_search = r_search_cnt + 1'b1;
                end
            end
            S_TRACK: begin
                if (w_prox_f) begin
                    w_next_state = S_STOP;
                end else if (!w_valid) begin
                    if (r_lost_cnt == c_lost_last) w_next_state = S_SEARCH;
                    else                           w_next_lost  = r_lost_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (!w_prox_f)                               w_next_state = S_SEARCH;
                else if (w_valid && w_idx == c_centre_idx)   w_next_state = S_ARRIVED;
            end
            S_ARRIVED: begin
                w_next_state     = S_WAIT_ACK;
                w_next_overwrite = 1'b0;
            end
            S_WAIT_ACK: begin
                if (button1)          w_next_state = S_IDLE;
                else if (w_bell_rise) w_next_state = S_RECALL;
            end
            S_RECALL: begin
                w_next_state = S_SEARCH;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered; an invalid frame in TRACK keeps the last steer.
        case (w_next_state)
            S_SEARCH: begin
                w_next_motor = c_mot_spin;
                w_next_turn  = '0;
            end
            S_TRACK: begin
                if (w_valid) begin
                    w_next_motor = w_dir;
                    w_next_turn  = w_turn;
                end
            end
            default: begin
                w_next_motor = c_mot_stop;
                w_next_turn  = '0;
            end
        endcase

        if (w_next_state == S_RECALL) w_next_overwrite = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_motor      <= c_mot_stop;
            r_turn       <= '0;
            r_overwrite  <= 1'b0;
            r_timeout    <= 1'b0;
            r_prox_cnt   <= '0;
            r_lost_cnt   <= '0;
            r_search_cnt <= '0;
            r_bell_q     <= 1'b0;
            r_bell_seen  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_motor      <= w_next_motor;
            r_turn       <= w_next_turn;
            r_overwrite  <= w_next_overwrite;
            r_timeout    <= w_next_timeout;
            r_prox_cnt   <= w_next_prox;
            r_lost_cnt   <= w_next_lost;
            r_search_cnt <= w_next_search;
            r_bell_q     <= bell;
            r_bell_seen  <= 1'b1;
        end
    end

    assign motor_state    = r_motor;
    assign turn_level     = r_turn;
    assign overwrite      = r_overwrite;
    assign search_timeout = r_timeout;
    assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_robot_nav_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_robot_nav_fsm
// Brief    : Scoreboard bench for robot_nav_fsm against a rule-level model.
// Revision : 1.0
// ============================================================================
module tb_robot_nav_fsm;

    localparam int ZONES = 5;
    localparam int PROX  = 4;
    localparam int LOST  = 3;
    localparam int TMO   = 20;
    localparam int CTR   = ZONES / 2;

    localparam int M_IDLE = 0, M_SEARCH = 1, M_TRACK = 2, M_STOP = 3;
    localparam int M_ARRIVED = 4, M_WAIT = 5, M_RECALL = 6;

    typedef struct packed {
        logic [4:0] motor;
        logic [1:0] turn;
        logic       ovr;
        logic       tmo;
        logic       busy;
    } exp_t;

    logic             CLOCK_50;
    logic             reset;
    logic             bell;
    logic             proximity;
    logic             button1;
    logic [ZONES-1:0] pixel_location;
    logic [4:0]       motor_state;
    logic [1:0]       turn_level;
    logic             overwrite;
    logic             search_timeout;
    logic             busy;

    robot_nav_fsm #(
        .ZONES(ZONES), .PROX_CYCLES(PROX), .LOST_HOLD(LOST), .SEARCH_TIMEOUT(TMO)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .bell(bell), .proximity(proximity),
        .button1(button1), .pixel_location(pixel_location), .motor_state(motor_state),
        .turn_level(turn_level), .overwrite(overwrite), .search_timeout(search_timeout),
        .busy(busy)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Model state, expressed as run lengths and ages rather than hardware counters.
    int         m_mode, m_turn, m_bell_prev, m_prox_run, m_search_age, m_lost_run;
    logic [4:0] m_motor;
    logic       m_ovr, m_tmo;

    function automatic exp_t model_out();
        exp_t e;
        e.motor = m_motor;
        e.turn  = 2'(m_turn);
        e.ovr   = m_ovr;
        e.tmo   = m_tmo;
        e.busy  = (m_mode != M_IDLE);
        return e;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_motor = 5'b00001; m_turn = 0; m_ovr = 1'b0; m_tmo = 1'b0;
        m_bell_prev = -1; m_prox_run = 0; m_search_age = 0; m_lost_run = 0;
    endtask

    task automatic model_step(input logic b, input logic p, input logic btn,
                              input logic [ZONES-1:0] pix);
        int  nm, idx;
        bit  rise, near, valid;
        rise  = b && (m_bell_prev == 0);
        near  = (m_prox_run >= PROX);
        valid = ($countones(pix) == 1);
        idx   = 0;
        for (int i = 0; i < ZONES; i++) if (pix[i]) idx = i;
        nm    = m_mode;
        m_tmo = 1'b0;
        case (m_mode)
            M_IDLE:    if (rise) nm = M_SEARCH;
            M_SEARCH:  if (valid) nm = M_TRACK;
                       else if (m_search_age == TMO - 1) begin nm = M_IDLE; m_tmo = 1'b1; end
            M_TRACK:   if (near) nm = M_STOP;
                       else if (!valid && m_lost_run == LOST - 1) nm = M_SEARCH;
            M_STOP:    if (!near) nm = M_SEARCH;
                       else if (valid && idx == CTR) nm = M_ARRIVED;
            M_ARRIVED: begin nm = M_WAIT; m_ovr = 1'b0; end
            M_WAIT:    if (btn) nm = M_IDLE; else if (rise) nm = M_RECALL;
            M_RECALL:  nm = M_SEARCH;
            default:   nm = M_IDLE;
        endcase
        m_search_age = (m_mode == M_SEARCH && nm == M_SEARCH) ? m_search_age + 1 : 0;
        m_lost_run   = (m_mode == M_TRACK && nm == M_TRACK && !valid) ? m_lost_run + 1 : 0;
        m_prox_run   = p ? m_prox_run + 1 : 0;
        if (nm == M_SEARCH) begin
            m_motor = 5'b10000; m_turn = 0;
        end else if (nm == M_TRACK) begin
            if (valid) begin
                m_turn  = (idx > CTR) ? idx - CTR : CTR - idx;
                m_motor = (idx == CTR) ? 5'b00010 : (idx < CTR) ? 5'b00100 : 5'b01000;
            end
        end else begin
            m_motor = 5'b00001; m_turn = 0;
        end
        if (nm == M_RECALL) m_ovr = 1'b1;
        m_mode      = nm;
        m_bell_prev = int'(b);
    endtask

    // Every task below starts and ends at a falling edge.
    task automatic step(input logic b, input logic p, input logic btn,
                        input logic [ZONES-1:0] pix);
        bell = b; proximity = p; button1 = btn; pixel_location = pix;
        model_step(b, p, btn, pix);
        sb.push_back(model_out());
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic apply_reset();
        exp_t got;
        reset = 1'b1;
        model_reset();
        #1;
        got = {motor_state, turn_level, overwrite, search_timeout, busy};
        checks++;
        if (got !== model_out()) begin
            errors++;
            $display("FAIL async_reset: got %b required %b", got, model_out());
        end
        sb.push_back(model_out());
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    initial begin
        exp_t e, got;
        forever begin
            @(posedge CLOCK_50);
            #1;
            cycle++;
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                got = {motor_state, turn_level, overwrite, search_timeout, busy};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL scoreboard cycle %0d: got motor=%b turn=%0d ovr=%b tmo=%b busy=%b, required motor=%b turn=%0d ovr=%b tmo=%b busy=%b",
                             cycle, got.motor, got.turn, got.ovr, got.tmo, got.busy,
                             e.motor, e.turn, e.ovr, e.tmo, e.busy);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic             rb, rp, rbtn;
        logic [ZONES-1:0] rpix;
        reset = 1'b1; bell = 1'b0; proximity = 1'b0; button1 = 1'b0; pixel_location = '0;
        model_reset();
        @(negedge CLOCK_50);
        apply_reset();

        // Summon, centre target, graded turns, lost-target hold-over.
        step(0, 0, 0, 5'b00000);
        step(1, 0, 0, 5'b00000);
        step(1, 0, 0, 5'b00100);
        step(1, 0, 0, 5'b00001);
        step(1, 0, 0, 5'b01000);
        step(1, 0, 0, 5'b00011);
        step(1, 0, 0, 5'b00011);
        step(1, 0, 0, 5'b00011);
        // Proximity debounce, stop, arrival.
        step(1, 0, 0, 5'b00100);
        repeat (3) step(1, 1, 0, 5'b00100);
        step(1, 0, 0, 5'b00100);
        repeat (5) step(1, 1, 0, 5'b00100);
        step(1, 1, 0, 5'b00100);
        step(1, 1, 0, 5'b00100);
        // Recall, then arrive again and acknowledge with a simultaneous bell edge.
        step(0, 1, 0, 5'b00000);
        step(1, 1, 0, 5'b00000);
        step(1, 0, 0, 5'b00000);
        step(1, 0, 0, 5'b10000);
        step(1, 0, 0, 5'b00100);
        repeat (5) step(1, 1, 0, 5'b00100);
        step(1, 1, 0, 5'b00100);
        step(0, 1, 0, 5'b00100);
        step(1, 1, 1, 5'b00100);
        step(1, 0, 0, 5'b00000);
        // Search timeout.
        step(0, 0, 0, 5'b00000);
        step(1, 0, 0, 5'b00000);
        repeat (22) step(1, 0, 0, 5'b00000);
        // Reset mid-track with bell held high.
        step(0, 0, 0, 5'b00000);
        step(1, 0, 0, 5'b00000);
        step(1, 0, 0, 5'b00010);
        bell = 1'b1;
        apply_reset();
        repeat (3) step(1, 0, 0, 5'b00010);
        step(0, 0, 0, 5'b00010);
        step(1, 0, 0, 5'b00010);

        rb = 1'b0; rp = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            if ($urandom_range(0, 4) == 0) rp = ~rp;
            rbtn = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0:       rpix = '0;
                1:       rpix = ZONES'($urandom);
                default: rpix = ZONES'(1) << $urandom_range(0, ZONES - 1);
            endcase
            if ($urandom_range(0, 149) == 0) begin
                bell = rb;
                apply_reset();
            end else begin
                step(rb, rp, rbtn, rpix);
            end
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
